// File: rtl/neuron_buffer_pingpong_ctrl_if.sv
// ----------------------------------------------------------------------------
// neuron_buffer_pingpong_ctrl_if
//
// Purpose : bundles the layer-controller handshake, the read/write address
//           streams and the status flags of the neuron buffer ping-pong
//           sequencer into one interface.
//
// Handshake rule (both streams): a beat transfers on a rising clk edge when
// the requester's signal (readReq / writeValid) and the matching ready
// (readReady / writeReady) are both high in that cycle. The address output is
// meaningful only in such a cycle. Requesters may raise or drop their request
// freely; ready never depends on the request in the same cycle.
//
// Signals:
//   layerStart        1-cycle pulse, starts a layer pass (controller -> ctrl)
//   readLast/writeLast index of last word per side for the pass
//   readReq           consumer asks for the next read word
//   readReady         read beat can be accepted this cycle
//   readBuffAddress   read-side buffer address
//   readValid         read data valid (one cycle after an accepted read)
//   writeValid        producer offers a word
//   writeReady        write beat can be accepted this cycle
//   writeBuffAddress  write-side buffer address
//   bufSel            0: N1 read / N2 write, 1: N2 read / N1 write
//   busy              sequencer not idle
//   layerDone         1-cycle pulse at pass completion
//   protocolErr       sticky protocol error flag
//   state_dbg         current FSM state encoding, for observation only
//
// Modports: master = controller/consumer/producer side, slave = sequencer.
// ----------------------------------------------------------------------------
interface neuron_buffer_pingpong_ctrl_if #(
    parameter int A = 7
);
    logic         layerStart;
    logic [A-1:0] readLast;
    logic [A-1:0] writeLast;
    logic         readReq;
    logic         readReady;
    logic [A-1:0] readBuffAddress;
    logic         readValid;
    logic         writeValid;
    logic         writeReady;
    logic [A-1:0] writeBuffAddress;
    logic         bufSel;
    logic         busy;
    logic         layerDone;
    logic         protocolErr;
    logic [1:0]   state_dbg;

    modport master (
        output layerStart, readLast, writeLast, readReq, writeValid,
        input  readReady, readBuffAddress, readValid, writeReady,
               writeBuffAddress, bufSel, busy, layerDone, protocolErr,
               state_dbg
    );

    modport slave (
        input  layerStart, readLast, writeLast, readReq, writeValid,
        output readReady, readBuffAddress, readValid, writeReady,
               writeBuffAddress, bufSel, busy, layerDone, protocolErr,
               state_dbg
    );
endinterface

// File: rtl/neuron_buffer_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// neuron_buffer_pingpong_ctrl
//
// Purpose : sequencer for the neuron buffer swapper. Owns the ping-pong role
//           of buffers N1/N2 (bufSel), generates the read address stream
//           toward the conv unit and the write address stream from the pool
//           unit, and swaps the roles at every layer boundary.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    neuron_buffer_pingpong_ctrl_if.slave (see interface header)
//
// FSM: IDLE -> RUN (on layerStart) -> DRAIN -> SWAP -> IDLE.
//   Ready and address outputs are combinational from state and pointers;
//   everything else is registered.
//
// Build option: define PINGPONG_ERRCHK_EN to build the sticky protocolErr
// checker; otherwise protocolErr is tied low.
// ----------------------------------------------------------------------------
module neuron_buffer_pingpong_ctrl #(
    parameter int A = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    neuron_buffer_pingpong_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] rd_ptr_q, rd_ptr_d;
    logic [A-1:0] wr_ptr_q, wr_ptr_d;
    logic [A-1:0] rd_last_q, rd_last_d;
    logic [A-1:0] wr_last_q, wr_last_d;
    logic         rd_done_q, rd_done_d;
    logic         wr_done_q, wr_done_d;
    logic         buf_sel_q, buf_sel_d;
    logic         read_valid_q, read_valid_d;
    logic         layer_done_q, layer_done_d;
    logic         busy_q, busy_d;

    logic read_ready;
    logic write_ready;
    logic rd_acc;
    logic wr_acc;

    // A finished side drops its ready and stops moving.
    assign read_ready  = (state_q == RUN) && !rd_done_q;
    assign write_ready = (state_q == RUN) && !wr_done_q;
    assign rd_acc      = bus.readReq && read_ready;
    assign wr_acc      = bus.writeValid && write_ready;

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_last_d    = rd_last_q;
        wr_last_d    = wr_last_q;
        rd_done_d    = rd_done_q;
        wr_done_d    = wr_done_q;
        buf_sel_d    = buf_sel_q;
        read_valid_d = 1'b0;
        layer_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.layerStart) begin
                    rd_last_d = bus.readLast;
                    wr_last_d = bus.writeLast;
                    rd_ptr_d  = '0;
                    wr_ptr_d  = '0;
                    rd_done_d = 1'b0;
                    wr_done_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // The last beat sets the done flag and leaves the pointer on
                // the last index, so a full 2^A pass never wraps to 0.
                if (rd_acc) begin
                    read_valid_d = 1'b1;
                    if (rd_ptr_q == rd_last_q) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + A'(1);
                    end
                end
                if (wr_acc) begin
                    if (wr_ptr_q == wr_last_q) begin
                        wr_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + A'(1);
                    end
                end
                // Uses the registered flags: the cycle after the final beat.
                if (rd_done_q && wr_done_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Toggle and pulse are launched here so both are visible
                // together while the FSM sits in SWAP.
                buf_sel_d    = ~buf_sel_q;
                layer_done_d = 1'b1;
                state_d      = SWAP;
            end
            SWAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_last_q    <= '0;
            wr_last_q    <= '0;
            rd_done_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            buf_sel_q    <= 1'b0;
            read_valid_q <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_last_q    <= rd_last_d;
            wr_last_q    <= wr_last_d;
            rd_done_q    <= rd_done_d;
            wr_done_q    <= wr_done_d;
            buf_sel_q    <= buf_sel_d;
            read_valid_q <= read_valid_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef PINGPONG_ERRCHK_EN
    logic prot_err_q, prot_err_d;

    // Requests only make sense in RUN; a new pass only from IDLE.
    always_comb begin
        prot_err_d = prot_err_q
                   | ((bus.readReq || bus.writeValid) && (state_q != RUN))
                   | (bus.layerStart && (state_q != IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prot_err_q <= 1'b0;
        end else begin
            prot_err_q <= prot_err_d;
        end
    end

    assign bus.protocolErr = prot_err_q;
`else
    assign bus.protocolErr = 1'b0;
`endif

    assign bus.readReady        = read_ready;
    assign bus.writeReady       = write_ready;
    assign bus.readBuffAddress  = rd_ptr_q;
    assign bus.writeBuffAddress = wr_ptr_q;
    assign bus.readValid        = read_valid_q;
    assign bus.bufSel           = buf_sel_q;
    assign bus.busy             = busy_q;
    assign bus.layerDone        = layer_done_q;
    assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_neuron_buffer_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// tb_neuron_buffer_pingpong_ctrl
//
// Table of layer passes plus random passes and hand-written reset / idle
// sequences. Reference model: per-pass queues of expected read and write
// addresses (0..last), an "active pass" flag and a count of cycles since the
// final beat of the pass, from which ready, busy, layerDone, bufSel and
// protocolErr expectations follow.
// ----------------------------------------------------------------------------
module tb_neuron_buffer_pingpong_ctrl;

    localparam int A = 7;

    logic clk = 1'b0;
    logic reset;

    neuron_buffer_pingpong_ctrl_if #(.A(A)) bif ();

    neuron_buffer_pingpong_ctrl #(.A(A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: addresses still owed on each side in the current pass.
    logic [A-1:0] exp_rd_q[$];
    logic [A-1:0] exp_wr_q[$];

    bit m_active;   // a pass is in progress (busy expected)
    int m_since;    // edges since the final beat of the pass, -1 if none
    bit m_buf;      // expected bufSel
    bit m_rv;       // expected readValid
    bit m_err;      // expected protocolErr (checker build)

    int rd_beats;
    int wr_beats;
    int ld_count;

    typedef struct {
        int rl;
        int wl;
        int rd_pct;
        int wr_pct;
        int ls_pct;
        int exp_r;
        int exp_w;
        bit exp_buf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_rd_q.delete();
        exp_wr_q.delete();
        m_active = 1'b0;
        m_since  = -1;
        m_buf    = 1'b0;
        m_rv     = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic drive(input bit rq, input bit wv, input bit ls,
                         input logic [A-1:0] rl, input logic [A-1:0] wl);
        bif.readReq    = rq;
        bif.writeValid = wv;
        bif.layerStart = ls;
        bif.readLast   = rl;
        bif.writeLast  = wl;
    endtask

    // One clock: check outputs at negedge against the model, advance the
    // model for the coming edge, then return 1 time unit after the posedge.
    task automatic step();
        bit exp_rr, exp_wr, rd_acc, wr_acc, start_ok;
        logic [A-1:0] a;
        @(negedge clk);
        exp_rr = m_active && (exp_rd_q.size() > 0);
        exp_wr = m_active && (exp_wr_q.size() > 0);
        check("readReady",  32'(bif.readReady),  32'(exp_rr));
        check("writeReady", 32'(bif.writeReady), 32'(exp_wr));
        check("readValid",  32'(bif.readValid),  32'(m_rv));
        check("busy",       32'(bif.busy),       32'(m_active));
        check("layerDone",  32'(bif.layerDone),  32'(m_since == 3));
        check("bufSel",     32'(bif.bufSel),     32'(m_buf));
`ifdef PINGPONG_ERRCHK_EN
        check("protocolErr", 32'(bif.protocolErr), 32'(m_err));
`else
        check("protocolErr", 32'(bif.protocolErr), 32'(0));
`endif
        if (bif.layerDone === 1'b1) ld_count++;

        rd_acc = bif.readReq && exp_rr;
        wr_acc = bif.writeValid && exp_wr;
        if (rd_acc) begin
            a = exp_rd_q.pop_front();
            check("readAddr", 32'(bif.readBuffAddress), 32'(a));
            rd_beats++;
        end
        if (wr_acc) begin
            a = exp_wr_q.pop_front();
            check("writeAddr", 32'(bif.writeBuffAddress), 32'(a));
            wr_beats++;
        end

        // Model update for the coming edge (all decisions use pre-edge view).
        if (((bif.readReq || bif.writeValid) && (!m_active || m_since >= 2)) ||
            (bif.layerStart && m_active))
            m_err = 1'b1;
        start_ok = bif.layerStart && !m_active;
        m_rv = rd_acc;
        if (m_since >= 1) begin
            m_since++;
            if (m_since == 3) m_buf = ~m_buf;
            if (m_since == 4) begin
                m_active = 1'b0;
                m_since  = -1;
            end
        end else if (m_active && (rd_acc || wr_acc) &&
                     exp_rd_q.size() == 0 && exp_wr_q.size() == 0) begin
            m_since = 1;
        end
        if (start_ok) begin
            m_active = 1'b1;
            m_since  = -1;
            for (int i = 0; i <= int'(bif.readLast); i++) exp_rd_q.push_back(A'(i));
            for (int i = 0; i <= int'(bif.writeLast); i++) exp_wr_q.push_back(A'(i));
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one full pass from IDLE; returns when the model is idle again.
    task automatic run_pass(input int rl, input int wl, input int rd_pct,
                            input int wr_pct, input int ls_pct);
        int n;
        rd_beats = 0;
        wr_beats = 0;
        ld_count = 0;
        drive(1'b0, 1'b0, 1'b1, A'(rl), A'(wl));
        step();
        n = 0;
        while (m_active && n < 3000) begin
            drive(32'($urandom_range(99)) < 32'(rd_pct),
                  32'($urandom_range(99)) < 32'(wr_pct),
                  32'($urandom_range(99)) < 32'(ls_pct),
                  A'($urandom), A'($urandom));
            step();
            n++;
        end
        check("pass_timeout", 32'(n >= 3000), 32'(0));
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'(0));
        check("wr_queue_empty", 32'(exp_wr_q.size()), 32'(0));
    endtask

    initial begin
        vecs[0] = '{rl: 3,   wl: 3,   rd_pct: 100, wr_pct: 100, ls_pct: 0,  exp_r: 4,   exp_w: 4,   exp_buf: 1'b1};
        vecs[1] = '{rl: 0,   wl: 5,   rd_pct: 100, wr_pct: 60,  ls_pct: 0,  exp_r: 1,   exp_w: 6,   exp_buf: 1'b0};
        vecs[2] = '{rl: 0,   wl: 0,   rd_pct: 100, wr_pct: 100, ls_pct: 0,  exp_r: 1,   exp_w: 1,   exp_buf: 1'b1};
        vecs[3] = '{rl: 127, wl: 127, rd_pct: 100, wr_pct: 100, ls_pct: 0,  exp_r: 128, exp_w: 128, exp_buf: 1'b0};
        vecs[4] = '{rl: 10,  wl: 2,   rd_pct: 50,  wr_pct: 70,  ls_pct: 0,  exp_r: 11,  exp_w: 3,   exp_buf: 1'b1};
        vecs[5] = '{rl: 5,   wl: 5,   rd_pct: 100, wr_pct: 100, ls_pct: 50, exp_r: 6,   exp_w: 6,   exp_buf: 1'b0};
        vecs[6] = '{rl: 20,  wl: 40,  rd_pct: 30,  wr_pct: 80,  ls_pct: 10, exp_r: 21,  exp_w: 41,  exp_buf: 1'b1};

        // Power-on reset: outputs must be at reset values while reset is high.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();
        #1;
        check("rst_busy",     32'(bif.busy),        32'(0));
        check("rst_bufSel",   32'(bif.bufSel),      32'(0));
        check("rst_readReady",32'(bif.readReady),   32'(0));
        check("rst_readValid",32'(bif.readValid),   32'(0));
        check("rst_layerDone",32'(bif.layerDone),   32'(0));
        check("rst_protoErr", 32'(bif.protocolErr), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven passes, back to back.
        for (int v = 0; v < 7; v++) begin
            run_pass(vecs[v].rl, vecs[v].wl, vecs[v].rd_pct, vecs[v].wr_pct, vecs[v].ls_pct);
            check("vec_read_beats",  32'(rd_beats), 32'(vecs[v].exp_r));
            check("vec_write_beats", 32'(wr_beats), 32'(vecs[v].exp_w));
            check("vec_layerDone_n", 32'(ld_count), 32'(1));
            check("vec_bufSel",      32'(bif.bufSel), 32'(vecs[v].exp_buf));
            if (vecs[v].rl == 127) begin
                // Pointers must hold on the top index rather than wrap.
                check("max_rd_hold", 32'(bif.readBuffAddress),  32'(127));
                check("max_wr_hold", 32'(bif.writeBuffAddress), 32'(127));
            end
        end

        // Requests while idle: no readiness, no pointer motion, error flagged
        // in the checker build.
        drive(1'b1, 1'b1, 1'b0, '0, '0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        step();
`ifdef PINGPONG_ERRCHK_EN
        check("idle_req_err", 32'(bif.protocolErr), 32'(1));
`else
        check("idle_req_err", 32'(bif.protocolErr), 32'(0));
`endif
        run_pass(2, 1, 100, 100, 0);
        check("after_idle_rd_beats", 32'(rd_beats), 32'(3));
        check("after_idle_wr_beats", 32'(wr_beats), 32'(2));

        // Random passes.
        for (int k = 0; k < 6; k++) begin
            int rl, wl;
            rl = $urandom_range(0, 15);
            wl = $urandom_range(0, 15);
            run_pass(rl, wl, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 10));
            check("rnd_read_beats",  32'(rd_beats), 32'(rl + 1));
            check("rnd_write_beats", 32'(wr_beats), 32'(wl + 1));
            check("rnd_layerDone_n", 32'(ld_count), 32'(1));
        end

        // Mid-pass reset with bufSel=1.
        if (!m_buf) run_pass(1, 1, 100, 100, 0);
        drive(1'b0, 1'b0, 1'b1, A'(20), A'(20));
        step();
        drive(1'b1, 1'b1, 1'b0, '0, '0);
        step();
        step();
        check("pre_rst_bufSel", 32'(bif.bufSel), 32'(1));
        check("pre_rst_busy",   32'(bif.busy),   32'(1));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy",      32'(bif.busy),        32'(0));
        check("midrst_bufSel",    32'(bif.bufSel),      32'(0));
        check("midrst_readValid", 32'(bif.readValid),   32'(0));
        check("midrst_protoErr",  32'(bif.protocolErr), 32'(0));
        check("midrst_readReady", 32'(bif.readReady),   32'(0));
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Recovery pass after reset.
        run_pass(3, 0, 100, 100, 0);
        check("post_rst_read_beats",  32'(rd_beats), 32'(4));
        check("post_rst_write_beats", 32'(wr_beats), 32'(1));
        check("post_rst_bufSel",      32'(bif.bufSel), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
